ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline. It consumes the decoded operands and control fields held by the ID/EX pipeline register and applies forwarding. It performs the ALU operation, or runs an iterative 32-cycle multiply/divide into HI/LO while stalling the front end. Results, store data, destination register and MEM/WB control are registered into the EX/MEM boundary.

---
 rtl/ex_pkg.sv | 44 ++++
 rtl/ex_stage_md.sv | 144 ++++++++++++++
 rtl/ex_stage.sv | 152 +++++++++++++++
 tb/tb_ex_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUop, funct, forwarding selects, MD FSM states.
// No logic of its own; constants and one decode helper only.
// Backpressure: n/a.
package ex_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   localparam logic [1:0] FWD_IDEX  = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

   // Encoded so that funct[1:0] of the MD group maps straight onto the op.
   typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

   function automatic logic is_md_funct(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

endpackage

// File: rtl/ex_stage_md.sv
// Iterative multiply/divide engine owning HI/LO: shift-add multiply, restoring divide on magnitudes.
// Latency: start edge, MD_CYCLES BUSY iterations, HI/LO written on entry to DONE.
// Backpressure: busy tells the owner to stall; flush abandons the operation leaving HI/LO untouched.
module md_unit
   import ex_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  md_op_t          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int            CW   = $clog2(MD_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

   md_state_t         state, state_nxt;
   logic [CW-1:0]     count;
   md_op_t            op_q;
   logic [XLEN-1:0]   work_hi, work_lo, operand_b, dividend_raw;
   logic              neg_q, neg_r, b_zero;
   logic              in_signed, a_neg, b_neg, op_is_div;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     madd, dshift;
   logic              d_ge;
   logic [XLEN-1:0]   dsub;
   logic [XLEN-1:0]   step_hi, step_lo, fin_hi, fin_lo;
   logic [2*XLEN-1:0] prod, prod_fix;

   // Magnitudes of the incoming operands; only signed ops look at the sign bits.
   always_comb begin
      in_signed = (op == MD_MULT) || (op == MD_DIV);
      a_neg     = in_signed & a[XLEN-1];
      b_neg     = in_signed & b[XLEN-1];
      mag_a     = a_neg ? -a : a;
      mag_b     = b_neg ? -b : b;
   end

   // One iteration of the datapath plus the sign/zero fix-up applied on the final step.
   always_comb begin
      op_is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
      madd      = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_b} : {(XLEN+1){1'b0}});
      dshift    = {work_hi, work_lo[XLEN-1]};
      d_ge      = dshift >= {1'b0, operand_b};
      dsub      = dshift[XLEN-1:0] - operand_b;
      if (op_is_div) begin
         step_hi = d_ge ? dsub : dshift[XLEN-1:0];
         step_lo = {work_lo[XLEN-2:0], d_ge};
      end else begin
         step_hi = madd[XLEN:1];
         step_lo = {madd[0], work_lo[XLEN-1:1]};
      end
      prod     = {step_hi, step_lo};
      prod_fix = neg_q ? -prod : prod;
      if (!op_is_div) begin
         fin_hi = prod_fix[2*XLEN-1:XLEN];
         fin_lo = prod_fix[XLEN-1:0];
      end else if (b_zero) begin
         fin_hi = dividend_raw;
         fin_lo = '1;
      end else begin
         fin_hi = neg_r ? -step_hi : step_hi;
         fin_lo = neg_q ? -step_lo : step_lo;
      end
   end

   // Next-state logic: flush abandons BUSY/DONE, DONE always returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !flush) state_nxt = BUSY;
         BUSY:    if (flush) state_nxt = IDLE;
                  else if (count == LAST) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register, operand latch, iteration registers and HI/LO write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         op_q         <= MD_MULT;
         work_hi      <= '0;
         work_lo      <= '0;
         operand_b    <= '0;
         dividend_raw <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         b_zero       <= 1'b0;
         hi           <= '0;
         lo           <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  op_q         <= op;
                  count        <= '0;
                  work_hi      <= '0;
                  neg_q        <= a_neg ^ b_neg;
                  neg_r        <= a_neg;
                  b_zero       <= (b == '0);
                  dividend_raw <= a;
                  if ((op == MD_DIV) || (op == MD_DIVU)) begin
                     work_lo   <= mag_a;
                     operand_b <= mag_b;
                  end else begin
                     work_lo   <= mag_b;
                     operand_b <= mag_a;
                  end
               end
            end
            BUSY: begin
               if (flush) begin
                  count <= '0;
               end else begin
                  work_hi <= step_hi;
                  work_lo <= step_lo;
                  count   <= count + CW'(1);
                  if (count == LAST) begin
                     hi <= fin_hi;
                     lo <= fin_lo;
                  end
               end
            end
            default: count <= '0;
         endcase
      end
   end

   assign busy = (state == BUSY);
   assign done = (state == DONE);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, branch target, MD engine control and the EX/MEM register.
// Latency: one cycle ID/EX -> EX/MEM; MULT/DIV family holds stall_out for 1 + MD_CYCLES cycles.
// Backpressure: stall_out freezes the front end; EX/MEM takes a bubble while stalled or flushed.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] register1_in,
   input  logic [XLEN-1:0] register2_in,
   input  logic [XLEN-1:0] sign_extend_in,
   input  logic [4:0]      rt_in,
   input  logic [4:0]      rd_in,
   input  logic            wb_src_in,
   input  logic            wb_write_in,
   input  logic            mem_read_in,
   input  logic            mem_write_in,
   input  logic            jump_in,
   input  logic [1:0]      ex_ALUop_in,
   input  logic            ex_ALUsrc_in,
   input  logic [1:0]      fwd_a_sel,
   input  logic [1:0]      fwd_b_sel,
   input  logic [XLEN-1:0] exmem_fwd_data,
   input  logic [XLEN-1:0] memwb_fwd_data,
   input  logic            flush,
   output logic            stall_out,
   output logic [XLEN-1:0] alu_result_out,
   output logic [XLEN-1:0] store_data_out,
   output logic [XLEN-1:0] branch_target_out,
   output logic [4:0]      dest_out,
   output logic            zero_out,
   output logic            wb_src_out,
   output logic            wb_write_out,
   output logic            mem_read_out,
   output logic            mem_write_out,
   output logic            jump_out
);

   logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, md_hi, md_lo, diff, branch_target;
   logic [5:0]      funct;
   logic [4:0]      shamt, dest;
   logic            is_rtype, md_in_ex, funct_ok, md_busy, md_done, md_start, bubble, wb_ok;

   assign funct    = sign_extend_in[5:0];
   assign shamt    = sign_extend_in[10:6];
   assign is_rtype = (ex_ALUop_in == ALUOP_FUNCT);
   assign md_in_ex = is_rtype && is_md_funct(funct);

   // Forwarding muxes; the unused select code falls back to the ID/EX value.
   always_comb begin
      case (fwd_a_sel)
         FWD_EXMEM: fwd_a = exmem_fwd_data;
         FWD_MEMWB: fwd_a = memwb_fwd_data;
         default:   fwd_a = register1_in;
      endcase
      case (fwd_b_sel)
         FWD_EXMEM: fwd_b = exmem_fwd_data;
         FWD_MEMWB: fwd_b = memwb_fwd_data;
         default:   fwd_b = register2_in;
      endcase
   end

   assign op_b = ex_ALUsrc_in ? sign_extend_in : fwd_b;

   // ALU; unknown funct gives zero and suppresses write-back via funct_ok.
   always_comb begin
      alu_res  = '0;
      funct_ok = 1'b1;
      case (ex_ALUop_in)
         ALUOP_SUB: alu_res = fwd_a - op_b;
         ALUOP_FUNCT: begin
            case (funct)
               F_ADD, F_ADDU: alu_res = fwd_a + op_b;
               F_SUB, F_SUBU: alu_res = fwd_a - op_b;
               F_AND:  alu_res = fwd_a & op_b;
               F_OR:   alu_res = fwd_a | op_b;
               F_XOR:  alu_res = fwd_a ^ op_b;
               F_NOR:  alu_res = ~(fwd_a | op_b);
               F_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
               F_SLTU: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
               F_SLL:  alu_res = op_b << shamt;
               F_SRL:  alu_res = op_b >> shamt;
               F_SRA:  alu_res = $signed(op_b) >>> shamt;
               F_MFHI: alu_res = md_hi;
               F_MFLO: alu_res = md_lo;
               F_MULT, F_MULTU, F_DIV, F_DIVU: alu_res = '0;
               default: funct_ok = 1'b0;
            endcase
         end
         default: alu_res = fwd_a + op_b;
      endcase
   end

   assign diff          = fwd_a - op_b;
   assign branch_target = pc_in + {sign_extend_in[XLEN-3:0], 2'b00};
   assign dest          = is_rtype ? rd_in : rt_in;
   assign wb_ok         = wb_write_in && (dest != 5'd0) && !md_in_ex && funct_ok;

   // The engine only accepts a new op from IDLE, so a held MD instruction in DONE does not restart.
   assign md_start  = md_in_ex && !flush && !md_busy && !md_done;
   assign stall_out = md_start || md_busy;
   assign bubble    = stall_out || flush || md_in_ex;

   md_unit #(
      .XLEN      (XLEN),
      .MD_CYCLES (MD_CYCLES)
   ) u_md (
      .clk   (clk),
      .rst   (rst),
      .start (md_start),
      .flush (flush),
      .op    (md_op_t'(funct[1:0])),
      .a     (fwd_a),
      .b     (fwd_b),
      .busy  (md_busy),
      .done  (md_done),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   // EX/MEM register: reset clears everything, stall/flush/MD retire capture a control bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_result_out    <= '0;
         store_data_out    <= '0;
         branch_target_out <= '0;
         dest_out          <= '0;
         zero_out          <= 1'b0;
         wb_src_out        <= 1'b0;
         wb_write_out      <= 1'b0;
         mem_read_out      <= 1'b0;
         mem_write_out     <= 1'b0;
         jump_out          <= 1'b0;
      end else begin
         alu_result_out    <= alu_res;
         store_data_out    <= fwd_b;
         branch_target_out <= branch_target;
         dest_out          <= dest;
         zero_out          <= (diff == '0);
         wb_src_out        <= wb_src_in;
         wb_write_out      <= bubble ? 1'b0 : wb_ok;
         mem_read_out      <= bubble ? 1'b0 : mem_read_in;
         mem_write_out     <= bubble ? 1'b0 : mem_write_in;
         jump_out          <= bubble ? 1'b0 : jump_in;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, forwarding, MD engine, flush, reset, branch target.
// Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
// Every wait on the DUT is bounded.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_in, register1_in, register2_in, sign_extend_in, exmem_fwd_data, memwb_fwd_data;
   logic [4:0]  rt_in, rd_in;
   logic        wb_src_in, wb_write_in, mem_read_in, mem_write_in, jump_in, ex_ALUsrc_in, flush;
   logic [1:0]  ex_ALUop_in, fwd_a_sel, fwd_b_sel;
   logic        stall_out, zero_out, wb_src_out, wb_write_out, mem_read_out, mem_write_out, jump_out;
   logic [31:0] alu_result_out, store_data_out, branch_target_out;
   logic [4:0]  dest_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .register1_in(register1_in), .register2_in(register2_in),
      .sign_extend_in(sign_extend_in), .rt_in(rt_in), .rd_in(rd_in), .wb_src_in(wb_src_in),
      .wb_write_in(wb_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .jump_in(jump_in), .ex_ALUop_in(ex_ALUop_in), .ex_ALUsrc_in(ex_ALUsrc_in),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .exmem_fwd_data(exmem_fwd_data),
      .memwb_fwd_data(memwb_fwd_data), .flush(flush), .stall_out(stall_out),
      .alu_result_out(alu_result_out), .store_data_out(store_data_out),
      .branch_target_out(branch_target_out), .dest_out(dest_out), .zero_out(zero_out),
      .wb_src_out(wb_src_out), .wb_write_out(wb_write_out), .mem_read_out(mem_read_out),
      .mem_write_out(mem_write_out), .jump_out(jump_out)
   );

   task automatic idle_inputs();
      pc_in = '0; register1_in = '0; register2_in = '0; sign_extend_in = '0;
      exmem_fwd_data = '0; memwb_fwd_data = '0; rt_in = '0; rd_in = '0;
      wb_src_in = 0; wb_write_in = 0; mem_read_in = 0; mem_write_in = 0; jump_in = 0;
      ex_ALUop_in = 2'b00; ex_ALUsrc_in = 0; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; flush = 0;
   endtask

   task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [4:0] sh);
      idle_inputs();
      ex_ALUop_in = 2'b10; register1_in = a; register2_in = b;
      rd_in = rd; rt_in = 5'd9; sign_extend_in = {21'b0, sh, f}; wb_write_in = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues an MD instruction, holds it while stalled, returns stall length and any leaked mem_read.
   task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic leaked);
      @(negedge clk);
      set_r(f, a, b, 5'd0, 5'd0);
      mem_read_in = 1'b1;
      #1;
      n = 0;
      leaked = 1'b0;
      while (stall_out === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         #1;
         if (mem_read_out !== 1'b0) leaked = 1'b1;
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      @(negedge clk); set_r(6'h10, 32'h0, 32'h0, 5'd4, 5'd0); tick(); hi = alu_result_out;
      @(negedge clk); set_r(6'h12, 32'h0, 32'h0, 5'd4, 5'd0); tick(); lo = alu_result_out;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) tick();
      total++; if (alu_result_out !== 32'h0) begin bad++; $display("FAIL rst_alu got=%h want=0", alu_result_out); end
      total++; if (wb_write_out !== 1'b0) begin bad++; $display("FAIL rst_wb got=%b want=0", wb_write_out); end
      total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall_out); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      @(negedge clk); set_r(6'h20, 32'd5, 32'd7, 5'd3, 5'd0); tick();
      total++; if (alu_result_out !== 32'd12) begin bad++; $display("FAIL add_res got=%h want=c", alu_result_out); end
      total++; if (dest_out !== 5'd3) begin bad++; $display("FAIL add_dest got=%0d want=3", dest_out); end
      total++; if (wb_write_out !== 1'b1) begin bad++; $display("FAIL add_wb got=%b want=1", wb_write_out); end
      // back-to-back: same ADD but to $0 must not write
      @(negedge clk); set_r(6'h20, 32'd5, 32'd7, 5'd0, 5'd0); tick();
      total++; if (wb_write_out !== 1'b0) begin bad++; $display("FAIL add_r0_wb got=%b want=0", wb_write_out); end
      // immediate add with wrap, destination taken from rt
      @(negedge clk); idle_inputs(); register1_in = 32'h10; sign_extend_in = 32'hFFFF_FFFF;
      ex_ALUsrc_in = 1'b1; rt_in = 5'd6; wb_write_in = 1'b1; tick();
      total++; if (alu_result_out !== 32'hF) begin bad++; $display("FAIL addi_res got=%h want=f", alu_result_out); end
      total++; if (dest_out !== 5'd6) begin bad++; $display("FAIL addi_dest got=%0d want=6", dest_out); end
   endtask

   task automatic test_fwd();
      @(negedge clk); set_r(6'h22, 32'h99, 32'h3, 5'd5, 5'd0);
      fwd_a_sel = 2'b01; exmem_fwd_data = 32'h10; tick();
      total++; if (alu_result_out !== 32'hD) begin bad++; $display("FAIL fwd_sub got=%h want=d", alu_result_out); end
      @(negedge clk); set_r(6'h2A, 32'h5, 32'h99, 5'd5, 5'd0);
      fwd_b_sel = 2'b10; memwb_fwd_data = 32'h10; tick();
      total++; if (alu_result_out !== 32'h1) begin bad++; $display("FAIL fwd_slt got=%h want=1", alu_result_out); end
      total++; if (store_data_out !== 32'h10) begin bad++; $display("FAIL fwd_store got=%h want=10", store_data_out); end
   endtask

   task automatic test_alu_misc();
      @(negedge clk); set_r(6'h2A, 32'h1, 32'hFFFF_FFFF, 5'd5, 5'd0); tick();
      total++; if (alu_result_out !== 32'h0) begin bad++; $display("FAIL slt_neg got=%h want=0", alu_result_out); end
      @(negedge clk); set_r(6'h2B, 32'h1, 32'hFFFF_FFFF, 5'd5, 5'd0); tick();
      total++; if (alu_result_out !== 32'h1) begin bad++; $display("FAIL sltu got=%h want=1", alu_result_out); end
      @(negedge clk); set_r(6'h03, 32'h0, 32'h8000_0000, 5'd5, 5'd4); tick();
      total++; if (alu_result_out !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h want=f8000000", alu_result_out); end
      @(negedge clk); set_r(6'h27, 32'h0F0F_0000, 32'h0000_00F0, 5'd5, 5'd0); tick();
      total++; if (alu_result_out !== 32'hF0F0_FF0F) begin bad++; $display("FAIL nor got=%h want=f0f0ff0f", alu_result_out); end
      @(negedge clk); set_r(6'h3F, 32'd5, 32'd7, 5'd5, 5'd0); tick();
      total++; if (alu_result_out !== 32'h0) begin bad++; $display("FAIL unk_res got=%h want=0", alu_result_out); end
      total++; if (wb_write_out !== 1'b0) begin bad++; $display("FAIL unk_wb got=%b want=0", wb_write_out); end
      @(negedge clk); set_r(6'h20, 32'd5, 32'd7, 5'd3, 5'd0); flush = 1'b1; tick();
      total++; if (wb_write_out !== 1'b0) begin bad++; $display("FAIL flush_idle_wb got=%b want=0", wb_write_out); end
   endtask

   task automatic test_mult();
      int n; logic leaked; logic [31:0] hi, lo;
      run_md(6'h18, 32'hFFFF_FFFF, 32'd2, n, leaked);
      total++; if (n !== 33) begin bad++; $display("FAIL mult_stall_cycles got=%0d want=33", n); end
      total++; if (leaked !== 1'b0) begin bad++; $display("FAIL mult_stall_bubble got=%b want=0", leaked); end
      tick();
      total++; if (wb_write_out !== 1'b0 || mem_read_out !== 1'b0) begin bad++;
         $display("FAIL mult_retire_bubble wb=%b rd=%b want=0 0", wb_write_out, mem_read_out); end
      read_hilo(hi, lo);
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
      total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got=%h want=fffffffe", lo); end
      run_md(6'h19, 32'hFFFF_FFFF, 32'd2, n, leaked);
      read_hilo(hi, lo);
      total++; if (hi !== 32'h1) begin bad++; $display("FAIL multu_hi got=%h want=1", hi); end
      total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h want=fffffffe", lo); end
   endtask

   task automatic test_div();
      int n; logic leaked; logic [31:0] hi, lo;
      run_md(6'h1A, 32'hFFFF_FFF9, 32'd2, n, leaked);
      read_hilo(hi, lo);
      total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
      run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, n, leaked);
      read_hilo(hi, lo);
      total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h want=80000000", lo); end
      total++; if (hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi got=%h want=0", hi); end
      run_md(6'h1B, 32'd7, 32'd0, n, leaked);
      read_hilo(hi, lo);
      total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0_lo got=%h want=ffffffff", lo); end
      total++; if (hi !== 32'h7) begin bad++; $display("FAIL divu0_hi got=%h want=7", hi); end
   endtask

   task automatic test_flush_busy();
      logic [31:0] hi, lo;
      @(negedge clk); set_r(6'h18, 32'd3, 32'd3, 5'd0, 5'd0); #1;
      repeat (11) @(negedge clk);
      #1;
      total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL flush_pre_stall got=%b want=1", stall_out); end
      flush = 1'b1;
      tick();
      total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_stall_drop got=%b want=0", stall_out); end
      @(negedge clk); idle_inputs(); #1;
      total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b want=0", stall_out); end
      read_hilo(hi, lo);
      total++; if (hi !== 32'h7 || lo !== 32'hFFFF_FFFF) begin bad++;
         $display("FAIL flush_hilo_kept hi=%h lo=%h want=7 ffffffff", hi, lo); end
   endtask

   task automatic test_rst_busy();
      logic [31:0] hi, lo;
      @(negedge clk); set_r(6'h18, 32'd5, 32'd6, 5'd0, 5'd0);
      repeat (5) @(negedge clk);
      set_r(6'h20, 32'd5, 32'd7, 5'd3, 5'd0); pc_in = 32'h100; rst = 1'b1;
      tick();
      total++; if (alu_result_out !== 32'h0 || dest_out !== 5'd0 || branch_target_out !== 32'h0) begin bad++;
         $display("FAIL rst_mid_data alu=%h dest=%0d bt=%h want=0 0 0", alu_result_out, dest_out, branch_target_out); end
      @(negedge clk); rst = 1'b0; idle_inputs(); #1;
      total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b want=0", stall_out); end
      read_hilo(hi, lo);
      total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL rst_mid_hilo hi=%h lo=%h want=0 0", hi, lo); end
   endtask

   task automatic test_branch();
      @(negedge clk); idle_inputs(); ex_ALUop_in = 2'b01; register1_in = 32'd9; register2_in = 32'd9;
      pc_in = 32'h100; sign_extend_in = 32'd4; tick();
      total++; if (zero_out !== 1'b1) begin bad++; $display("FAIL beq_zero got=%b want=1", zero_out); end
      total++; if (branch_target_out !== 32'h110) begin bad++; $display("FAIL beq_target got=%h want=110", branch_target_out); end
      @(negedge clk); register2_in = 32'd8; tick();
      total++; if (zero_out !== 1'b0) begin bad++; $display("FAIL bne_zero got=%b want=0", zero_out); end
      total++; if (alu_result_out !== 32'h1) begin bad++; $display("FAIL bne_diff got=%h want=1", alu_result_out); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_add();
      test_fwd();
      test_alu_misc();
      test_mult();
      test_div();
      test_flush_busy();
      test_rst_busy();
      test_branch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
